rx_byte_sequencer: RTL
======================

RX_BYTE_SEQUENCER -- requirements
Module: rx_byte_sequencer

Interface
REQ-001 SHALL have parameter NUM_BITS, default 8, meaning bits per assembled word (legal range 2..16).
REQ-002 SHALL have parameter SHIFT_MSB, default 0, meaning the first received bit ends up in byte_data[0] when 0, or in byte_data[NUM_BITS-1] when 1; it SHALL be passed through to the shift register instance.
REQ-003 SHALL have port clk, input, 1, the single clock; all state is on posedge clk.
REQ-004 SHALL have port n_rst, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have port enable, input, 1, packet active; low forces IDLE.
REQ-006 SHALL have port bit_strobe, input, 1, one-cycle pulse marking a valid decoded bit.
REQ-007 SHALL have port serial_in, input, 1, decoded bit, valid when bit_strobe=1.
REQ-008 SHALL have port eop, input, 1, end-of-packet pulse.
REQ-009 SHALL have port byte_ready, input, 1, consumer accept.
REQ-010 SHALL have port byte_data, output, NUM_BITS, held word.
REQ-011 SHALL have port byte_valid, output, 1, byte_data holds an unconsumed word.
REQ-012 SHALL have port bit_count, output, $clog2(NUM_BITS+1), bits shifted into the current partial word.
REQ-013 SHALL have port overrun, output, 1, sticky, cleared when enable=0.
REQ-014 SHALL have port partial_err, output, 1, one-cycle pulse.
REQ-015 SHALL have port stuff_err, output, 1, one-cycle pulse.
REQ-016 SHALL internally instantiate the team serial-to-parallel shift register (SHIFT_MSB passed through); it SHALL drive that register's shift_enable.

Function
REQ-017 SHALL implement FSM states IDLE, ACTIVE and LOAD.
REQ-018 SHALL go IDLE->ACTIVE when enable=1, and SHALL go to IDLE from any state when enable=0.
REQ-019 SHALL, in ACTIVE, pulse the shift register's shift_enable for exactly the cycle where bit_strobe=1 and the bit is not skipped; bit_count SHALL increment in the same cycle.
REQ-020 SHALL, on the strobe that makes bit_count reach NUM_BITS, wrap bit_count to 0 and go to LOAD for one cycle; in LOAD it SHALL copy the shift register output into byte_data, set byte_valid=1, and return to ACTIVE.
REQ-021 SHALL give a latency of 2 clocks from the final bit_strobe to byte_valid=1.
REQ-022 SHALL clear byte_valid on the clock where byte_valid=1 and byte_ready=1.
REQ-023 SHALL, in LOAD with byte_valid=1 and byte_ready=0, drop the new word, keep the old byte_data, and set overrun=1.
REQ-024 SHALL, in LOAD with byte_ready=1 in the same cycle, give LOAD priority: byte_valid stays 1, byte_data takes the new word, and overrun is not set.
REQ-025 SHALL, on eop=1, clear bit_count to 0, discard the partial word, and pulse partial_err if bit_count was nonzero; an eop coincident with the final bit_strobe SHALL complete the word (LOAD taken) with no partial_err.
REQ-026 SHALL ignore a bit_strobe received in the LOAD cycle; the sender SHALL guarantee strobes are at least 2 cycles apart.
REQ-027 SHALL, with enable=0, hold bit_count=0 and the shift register at reset value, and leave byte_valid/byte_data unchanged so the consumer can drain.

Reset
REQ-028 SHALL, while n_rst=0, set state=IDLE, bit_count=0, byte_data=0, byte_valid=0, overrun=0, partial_err=0, stuff_err=0, and the shift register to all ones.
REQ-029 SHALL, on reset mid-word or with byte_valid=1, lose all data immediately, without waiting for a clock edge.

Configuration
REQ-030 SHALL, when macro RX_BITSTUFF_SKIP_EN is defined, count consecutive shifted 1 bits; after 6 of them the next strobe is skipped (no shift, no bit_count change, ones counter cleared) and a skipped bit value of 1 pulses stuff_err. Any shifted 0, eop or enable=0 SHALL clear the ones counter.
REQ-031 SHALL, when RX_BITSTUFF_SKIP_EN is undefined, shift every strobe, tie stuff_err to 0, and omit the ones counter.

Verification
REQ-032 SHALL cover: enable=1, 8 strobes of bits 1,0,1,1,0,0,1,0 (SHIFT_MSB=0) -> byte_data=8'h4D, byte_valid=1 two cycles after the 8th strobe.
REQ-033 SHALL cover: 2 words, byte_ready held 0 -> first word retained, overrun=1 after 2nd LOAD, and overrun cleared after enable=0.
REQ-034 SHALL cover: byte_ready=1 in the LOAD cycle of word 2 -> byte_data=word 2, byte_valid=1, overrun=0.
REQ-035 SHALL cover: eop after 3 bits -> partial_err pulses once, bit_count=0, and the next 8 bits form a clean word.
REQ-036 SHALL cover, with RX_BITSTUFF_SKIP_EN defined: bits 1x6, 0, 1 -> 0 not shifted, bit_count=7, stuff_err=0; bits 1x6, 1 -> stuff_err pulse.
REQ-037 SHALL cover: n_rst low mid-word with byte_valid=1 -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/rx_byte_sequencer.sv
// rx_byte_sequencer: assembles strobed serial bits into NUM_BITS-wide words behind a one-deep hold register.
// Optional USB-style bit-stuff skipping is built in when RX_BITSTUFF_SKIP_EN is defined.

module rx_stp_shift_reg #(
    parameter int NUM_BITS  = 8,
    parameter int SHIFT_MSB = 0
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                clear,
    input  logic                shift_enable,
    input  logic                serial_in,
    output logic [NUM_BITS-1:0] parallel_out
);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            parallel_out <= '1;
        end else if (clear) begin
            parallel_out <= '1;
        end else if (shift_enable) begin
            if (SHIFT_MSB != 0) begin
                parallel_out <= {parallel_out[NUM_BITS-2:0], serial_in};
            end else begin
                parallel_out <= {serial_in, parallel_out[NUM_BITS-1:1]};
            end
        end
    end

endmodule

module rx_byte_sequencer #(
    parameter int NUM_BITS  = 8,
    parameter int SHIFT_MSB = 0
) (
    input  logic                         clk,
    input  logic                         n_rst,
    input  logic                         enable,
    input  logic                         bit_strobe,
    input  logic                         serial_in,
    input  logic                         eop,
    input  logic                         byte_ready,
    output logic [NUM_BITS-1:0]          byte_data,
    output logic                         byte_valid,
    output logic [$clog2(NUM_BITS+1)-1:0] bit_count,
    output logic                         overrun,
    output logic                         partial_err,
    output logic                         stuff_err
);

    localparam int CW = $clog2(NUM_BITS + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(NUM_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        LOAD
    } state_t;

    state_t              state;
    logic                strobe_ok;
    logic                skip_bit;
    logic                shift_enable;
    logic                last_bit;
    logic                sr_clear;
    logic [NUM_BITS-1:0] sr_out;

    always_comb begin
        strobe_ok    = enable && (state == ACTIVE) && bit_strobe;
        shift_enable = strobe_ok && !skip_bit;
        last_bit     = shift_enable && (bit_count == LAST_BIT);
        // An eop that lands on the final bit completes the word, so the register must keep it.
        sr_clear     = !enable || (eop && !last_bit);
    end

    rx_stp_shift_reg #(
        .NUM_BITS  (NUM_BITS),
        .SHIFT_MSB (SHIFT_MSB)
    ) u_shift_reg (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (sr_clear),
        .shift_enable (shift_enable),
        .serial_in    (serial_in),
        .parallel_out (sr_out)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state       <= IDLE;
            bit_count   <= '0;
            byte_data   <= '0;
            byte_valid  <= 1'b0;
            overrun     <= 1'b0;
            partial_err <= 1'b0;
        end else begin
            partial_err <= 1'b0;
            // Consumer handshake runs in every state so a disabled receiver can still drain.
            if (byte_valid && byte_ready) begin
                byte_valid <= 1'b0;
            end
            if (!enable) begin
                state     <= IDLE;
                bit_count <= '0;
                overrun   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= ACTIVE;
                    end
                    ACTIVE: begin
                        if (last_bit) begin
                            bit_count <= '0;
                            state     <= LOAD;
                        end else if (eop) begin
                            bit_count   <= '0;
                            partial_err <= (bit_count != '0);
                        end else if (shift_enable) begin
                            bit_count <= bit_count + CW'(1);
                        end
                    end
                    LOAD: begin
                        state <= ACTIVE;
                        // A word arriving in the same cycle as the accept replaces the old one.
                        if (byte_valid && !byte_ready) begin
                            overrun <= 1'b1;
                        end else begin
                            byte_data  <= sr_out;
                            byte_valid <= 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

`ifdef RX_BITSTUFF_SKIP_EN
    logic [2:0] ones_cnt;

    assign skip_bit = strobe_ok && (ones_cnt == 3'd6);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ones_cnt  <= '0;
            stuff_err <= 1'b0;
        end else begin
            stuff_err <= 1'b0;
            if (!enable || eop) begin
                ones_cnt <= '0;
            end else if (skip_bit) begin
                ones_cnt  <= '0;
                stuff_err <= serial_in;
            end else if (shift_enable) begin
                ones_cnt <= serial_in ? ones_cnt + 3'd1 : 3'd0;
            end
        end
    end
`else
    assign skip_bit  = 1'b0;
    assign stuff_err = 1'b0;
`endif

endmodule
